imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_pkg.sv | 28 ++
 rtl/imm_format.sv | 35 +++
 rtl/imm_gen_pipe.sv | 106 ++++++++++
 tb/tb_imm_gen_pipe.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared immediate-format encodings, buffer states and field constants for imm_gen_pipe.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_U     = 3'b011,
    IMM_J     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_ZIMM  = 3'b110,
    IMM_UNDEF = 3'b111
  } imm_src_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  localparam int INSTR_LSB  = 7;
  localparam int SHAMT_LSB  = 20;
  localparam int SHAMT32_W  = 5;
  localparam int SHAMT64_W  = 6;
  localparam int ZIMM_LSB   = 15;
  localparam int ZIMM_W     = 5;

endpackage

// File: rtl/imm_format.sv
// Combinational RISC-V immediate formatter. Build option IMM_ZIMM_EN enables the
// ZIMM (110) encoding; without it 110 is reported as illegal.
module imm_format
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:INSTR_LSB] instr,
  input  imm_src_e            immsrc,
  output logic [XLEN-1:0]     imm,
  output logic                illegal
);

  // Size casts of signed operands sign-extend from the top field bit (instr[31]).
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (immsrc)
      IMM_I:     imm = XLEN'($signed(instr[31:20]));
      IMM_S:     imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_B:     imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_U:     imm = XLEN'($signed({instr[31:12], 12'b0}));
      IMM_J:     imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      IMM_SHAMT: imm = (XLEN == 64) ? XLEN'(instr[SHAMT_LSB +: SHAMT64_W])
                                    : XLEN'(instr[SHAMT_LSB +: SHAMT32_W]);
`ifdef IMM_ZIMM_EN
      IMM_ZIMM:  imm = XLEN'(instr[ZIMM_LSB +: ZIMM_W]);
`else
      IMM_ZIMM:  illegal = 1'b1;
`endif
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a two-entry (main + skid) valid/ready output buffer.
// XLEN must be 32 or 64. Build option IMM_ZIMM_EN enables ZIMM decode.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:INSTR_LSB] in_instr,
  input  logic [2:0]          in_immsrc,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_imm,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_illegal
);

  logic [XLEN-1:0]  f_imm;
  logic             f_ill;

  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_ill;

  buf_state_e state_q, state_d;
  logic       acc, drn;
  logic       ld_main_in, ld_main_skid, ld_skid;

  imm_format #(.XLEN(XLEN)) u_fmt (
    .instr   (in_instr),
    .immsrc  (imm_src_e'(in_immsrc)),
    .imm     (f_imm),
    .illegal (f_ill)
  );

  assign out_valid = (state_q != BUF_EMPTY);
  assign acc       = in_valid & in_ready;
  assign drn       = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: if (acc) begin
          state_d    = BUF_ONE;
          ld_main_in = 1'b1;
        end
        BUF_ONE: begin
          if (acc && drn)      ld_main_in = 1'b1;
          else if (acc) begin
            state_d = BUF_FULL;
            ld_skid = 1'b1;
          end else if (drn)    state_d = BUF_EMPTY;
        end
        BUF_FULL: if (drn) begin
          state_d      = BUF_ONE;
          ld_main_skid = 1'b1;
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  // in_ready tracks the next state so it never depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= BUF_EMPTY;
      in_ready    <= 1'b1;
      out_imm     <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
      skid_imm    <= '0;
      skid_tag    <= '0;
      skid_ill    <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != BUF_FULL);
      if (ld_main_in) begin
        out_imm     <= f_imm;
        out_tag     <= in_tag;
        out_illegal <= f_ill;
      end else if (ld_main_skid) begin
        out_imm     <= skid_imm;
        out_tag     <= skid_tag;
        out_illegal <= skid_ill;
      end
      if (ld_skid) begin
        skid_imm <= f_imm;
        skid_tag <= in_tag;
        skid_ill <= f_ill;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and a queue-based model.
module tb_imm_gen_pipe;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic reset, flush, in_valid, out_ready;
  logic [31:7] in_instr;
  logic [2:0]  in_immsrc;
  logic [TAG_W-1:0] in_tag;

  logic r32, v32, il32, r64, v64, il64;
  logic [31:0] o32;
  logic [63:0] o64;
  logic [TAG_W-1:0] t32, t64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag), .out_valid(v32),
    .out_ready(out_ready), .out_imm(o32), .out_tag(t32), .out_illegal(il32));

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag), .out_valid(v64),
    .out_ready(out_ready), .out_imm(o64), .out_tag(t64), .out_illegal(il64));

  typedef struct {
    logic [63:0] i32;
    logic [63:0] i64;
    logic [TAG_W-1:0] tag;
    logic ill;
  } ent_t;

  ent_t q[$];
  int n_pass = 0;
  int n_total = 0;
  bit rst_seen = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Immediate value from the ISA field definitions, as a signed integer.
  task automatic ref_imm(input logic [31:0] ins, input logic [2:0] src, input int xlen,
                         output logic [63:0] v, output logic ill);
    longint s;
    s = 0;
    ill = 1'b0;
    case (src)
      3'd0: s = $signed(ins[31:20]);
      3'd1: s = $signed({ins[31:25], ins[11:7]});
      3'd2: s = $signed({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2;
      3'd3: s = $signed(ins[31:12]) * 4096;
      3'd4: s = $signed({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2;
      3'd5: s = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
`ifdef IMM_ZIMM_EN
      3'd6: s = longint'(ins[19:15]);
`else
      3'd6: ill = 1'b1;
`endif
      default: ill = 1'b1;
    endcase
    v = (xlen == 32) ? {32'b0, s[31:0]} : s;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] src,
                       input logic [TAG_W-1:0] tag);
    in_valid  = v;
    in_instr  = ins[31:7];
    in_immsrc = src;
    in_tag    = tag;
  endtask

  // One clock: update the model at the edge, then check every output mid-cycle.
  task automatic cycle();
    ent_t e;
    logic ill64;
    bit drn, acc;
    @(posedge clk);
    if (reset) begin
      q.delete();
      rst_seen = 1;
    end else begin
      rst_seen = 0;
      if (flush) q.delete();
      else begin
        drn = (q.size() > 0) && out_ready;
        acc = in_valid && (q.size() < 2);
        if (drn) void'(q.pop_front());
        if (acc) begin
          ref_imm({in_instr, 7'b0}, in_immsrc, 32, e.i32, e.ill);
          ref_imm({in_instr, 7'b0}, in_immsrc, 64, e.i64, ill64);
          e.tag = in_tag;
          q.push_back(e);
        end
      end
    end
    @(negedge clk);
    chk("valid32", 64'(v32), 64'(q.size() != 0));
    chk("valid64", 64'(v64), 64'(q.size() != 0));
    chk("ready32", 64'(r32), 64'(q.size() < 2));
    chk("ready64", 64'(r64), 64'(q.size() < 2));
    if (q.size() != 0) begin
      chk("imm32", 64'(o32), q[0].i32);
      chk("imm64", o64, q[0].i64);
      chk("tag32", 64'(t32), 64'(q[0].tag));
      chk("tag64", 64'(t64), 64'(q[0].tag));
      chk("ill32", 64'(il32), 64'(q[0].ill));
      chk("ill64", 64'(il64), 64'(q[0].ill));
    end else if (rst_seen) begin
      chk("rst_imm32", 64'(o32), 64'd0);
      chk("rst_imm64", o64, 64'd0);
      chk("rst_tag", 64'(t32), 64'd0);
      chk("rst_ill", 64'(il32 | il64), 64'd0);
    end
  endtask

  task automatic fill_full();
    out_ready = 1'b0;
    flush = 1'b0;
    drive(1'b1, 32'h00500093, 3'd0, 5'd7); cycle();
    drive(1'b1, 32'h00600093, 3'd0, 5'd8); cycle();
    drive(1'b0, 32'h0, 3'd0, 5'd0);
    chk("fill_ready", 64'(r32), 64'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 3'd0, 5'd0);
    cycle();
    chk("rst_ready", 64'(r32), 64'd1);
    chk("rst_valid", 64'(v32), 64'd0);
    reset = 1'b0;

    // ADDI x1,x0,-1 style I immediate
    drive(1'b1, 32'hFFF00093, 3'd0, 5'd1); cycle();
    chk("i_neg1", 64'(o32), 64'hFFFFFFFF);
    chk("i_ill", 64'(il32), 64'd0);
    drive(1'b1, 32'hFE000EE3, 3'd2, 5'd2); cycle();
    chk("b_neg4", 64'(o32), 64'hFFFFFFFC);
    drive(1'b1, 32'hFE000EE3, 3'd7, 5'd3); cycle();
    chk("undef_imm", 64'(o32), 64'd0);
    chk("undef_ill", 64'(il32), 64'd1);
    drive(1'b1, 32'h800000B7, 3'd3, 5'd4); cycle();
    chk("u64", o64, 64'hFFFFFFFF80000000);
    drive(1'b1, 32'h03F00013, 3'd5, 5'd5); cycle();
    chk("shamt64", o64, 64'h3F);
    chk("shamt32", 64'(o32), 64'h1F);
    drive(1'b1, 32'h000D8000, 3'd6, 5'd6); cycle();
`ifdef IMM_ZIMM_EN
    chk("zimm", 64'(o32), 64'h1B);
    chk("zimm_ill", 64'(il32), 64'd0);
`else
    chk("zimm", 64'(o32), 64'h0);
    chk("zimm_ill", 64'(il32), 64'd1);
`endif
    drive(1'b0, 32'h0, 3'd0, 5'd0); cycle();

    // Backpressure: three offers, two fit.
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 3'd0, 5'd1); cycle();
    drive(1'b1, 32'h00200093, 3'd0, 5'd2); cycle();
    chk("bp_ready", 64'(r32), 64'd0);
    drive(1'b1, 32'h00300093, 3'd0, 5'd3); cycle();
    chk("bp_t1", 64'(t32), 64'd1);
    out_ready = 1'b1; cycle();
    chk("bp_t2", 64'(t32), 64'd2);
    cycle();
    chk("bp_t3", 64'(t32), 64'd3);
    drive(1'b0, 32'h0, 3'd0, 5'd0); cycle();
    chk("bp_empty", 64'(v32), 64'd0);

    // Flush from FULL with a concurrent offer.
    fill_full();
    flush = 1'b1;
    drive(1'b1, 32'h00900093, 3'd0, 5'd9); cycle();
    chk("fl_valid", 64'(v32), 64'd0);
    chk("fl_ready", 64'(r32), 64'd1);
    flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 3'd0, 5'd0);
    repeat (3) cycle();
    // Flush in ONE while an entry is being accepted.
    drive(1'b1, 32'h00A00093, 3'd0, 5'd10); cycle();
    flush = 1'b1; out_ready = 1'b0;
    drive(1'b1, 32'h00B00093, 3'd0, 5'd11); cycle();
    flush = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 5'd0); out_ready = 1'b1;
    repeat (2) cycle();

    // Reset while FULL and stalled.
    fill_full();
    reset = 1'b1; cycle();
    chk("rf_valid", 64'(v32), 64'd0);
    chk("rf_imm", 64'(o32), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom % 97) == 0;
      flush     = ($urandom % 25) == 0;
      out_ready = ($urandom % 3) != 0;
      drive(($urandom % 4) != 0, $urandom, 3'($urandom % 8), TAG_W'($urandom));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
